// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 binary mux tree, one registered 2:1 level per select bit (latency SEL_W cycles).
// Per-stage valid/ready: empty stages keep filling under stall, in_ready drops only when every stage is full.
module mux_tree_pipe #(
  parameter int N_IN   = 16,
  parameter int DATA_W = 8,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_IN*DATA_W-1:0]   in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int L = SEL_W;

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int NP = N_IN >> k;

    logic [2*NP*DATA_W-1:0] w_prev;
    logic [SEL_W-1:0]       w_up_sel;
    logic                   w_up_vld;
    logic                   w_dn_rdy;
    logic                   w_rdy;
    logic [NP*DATA_W-1:0]   w_nxt;
    logic [NP*DATA_W-1:0]   r_dat;
    logic [SEL_W-1:0]       r_sel;
    logic                   r_vld;

    if (k == 1) begin : g_src
      assign w_prev   = in_data;
      assign w_up_sel = in_sel;
      assign w_up_vld = in_valid;
    end else begin : g_chain
      assign w_prev   = g_lvl[k-1].r_dat;
      assign w_up_sel = g_lvl[k-1].r_sel;
      assign w_up_vld = g_lvl[k-1].r_vld;
    end

    // Ready ripples back from the consumer; an empty stage always accepts.
    if (k == L) begin : g_last
      assign w_dn_rdy = out_ready;
    end else begin : g_mid
      assign w_dn_rdy = g_lvl[k+1].w_rdy;
    end
    assign w_rdy = w_dn_rdy | ~r_vld;

    // Each stage resolves one select bit, LSB first, using the sel that travels with its data.
    always_comb begin
      w_nxt = '0;
      for (int j = 0; j < NP; j++) begin
        w_nxt[j*DATA_W +: DATA_W] = w_up_sel[k-1] ? w_prev[(2*j+1)*DATA_W +: DATA_W]
                                                  : w_prev[(2*j)*DATA_W +: DATA_W];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
        r_dat <= '0;
        r_sel <= '0;
      end else if (w_rdy) begin
        r_vld <= w_up_vld;
        if (w_up_vld) begin
          r_dat <= w_nxt;
          r_sel <= w_up_sel;
        end
      end
    end
  end

  assign in_ready  = g_lvl[1].w_rdy;
  assign out_data  = g_lvl[L].r_dat;
  assign out_sel   = g_lvl[L].r_sel;
  assign out_valid = g_lvl[L].r_vld;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench for mux_tree_pipe (N_IN=16, DATA_W=8): directed latency/stream/stall/bubble/reset plus random traffic.
module tb_mux_tree_pipe;
  localparam int N  = 16;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] in_data;
  logic [3:0]      in_sel;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   out_data;
  logic [3:0]      out_sel;
  logic            out_valid;
  logic            out_ready;

  mux_tree_pipe #(.N_IN(N), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dat;
    logic [3:0] sel;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   out_cyc_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_out = 0;
  bit   lat_chk = 1'b0;
  bit   stall_prev = 1'b0;
  logic [11:0] hold_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
  endtask

  function automatic logic [N*DW-1:0] chans();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = 8'h10 + 8'(i);
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change at posedge+1, so at negedge the handshakes of the next edge are already decided.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data_sel", 32'({out_sel, out_data}), 32'(hold_val));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("out_data", 32'(out_data), 32'(e.dat));
          chk("out_sel", 32'(out_sel), 32'(e.sel));
          if (lat_chk) chk("latency", 32'(cyc - e.cyc), 32'd4);
        end
        n_out++;
        out_cyc_q.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        e.dat = in_data[in_sel*DW +: DW];
        e.sel = in_sel;
        e.cyc = cyc;
        sb.push_back(e);
        n_acc++;
      end
      stall_prev = out_valid && !out_ready;
      hold_val   = {out_sel, out_data};
    end
  end

  task automatic send(input logic [3:0] s, input logic [N*DW-1:0] d);
    int w = 0;
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int b_acc;
    int b_out;
    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Single transfer, sel 9
    lat_chk = 1'b1;
    b_out = n_out;
    send(4'd9, chans());
    drain();
    chk("single_count", 32'(n_out - b_out), 32'd1);

    // Back-to-back stream 0..15
    b_out = n_out;
    out_cyc_q.delete();
    for (int s = 0; s < N; s++) send(4'(s), chans());
    drain();
    chk("stream_count", 32'(n_out - b_out), 32'd16);
    for (int i = 1; i < out_cyc_q.size(); i++)
      chk("stream_gap", 32'(out_cyc_q[i] - out_cyc_q[i-1]), 32'd1);
    lat_chk = 1'b0;

    // Backpressure: 8 items against a stalled consumer
    b_acc = n_acc;
    b_out = n_out;
    out_ready = 1'b0;
    fork
      for (int s = 0; s < 8; s++) send(4'(s + 4), chans());
      begin
        repeat (10) @(negedge clk);
        chk("bp_accepted", 32'(n_acc - b_acc), 32'd4);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 32'(n_out - b_out), 32'd8);

    // Bubbles: valid 1,0,1,0 with sel 3,x,12,x
    lat_chk = 1'b1;
    b_out = n_out;
    out_cyc_q.delete();
    in_data = chans();
    in_valid = 1'b1; in_sel = 4'd3;  @(posedge clk); #1;
    in_valid = 1'b0; in_sel = 4'd7;  @(posedge clk); #1;
    in_valid = 1'b1; in_sel = 4'd12; @(posedge clk); #1;
    in_valid = 1'b0; in_sel = 4'd5;  @(posedge clk); #1;
    drain();
    chk("bubble_count", 32'(n_out - b_out), 32'd2);
    if (out_cyc_q.size() == 2) chk("bubble_spacing", 32'(out_cyc_q[1] - out_cyc_q[0]), 32'd2);
    else chk("bubble_outs", 32'(out_cyc_q.size()), 32'd2);
    lat_chk = 1'b0;

    // Reset with the pipe full and the consumer stalled
    out_ready = 1'b0;
    for (int s = 0; s < 4; s++) send(4'(15 - s), chans());
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_out_sel", 32'(out_sel), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    b_out = n_out;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_no_output", 32'(n_out - b_out), 32'd0);

    // Random traffic against the reference queue
    b_acc = n_acc;
    b_out = n_out;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_sel    = 4'($urandom_range(0, 15));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("rand_count", 32'(n_out - b_out), 32'(n_acc - b_acc));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
